// File: rtl/alu_rr_arbiter_if.sv
// Bundle of requester, ALU and response signals for alu_rr_arbiter.
// master = the arbiter, slave = requesters/ALU/response consumer.
interface alu_rr_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [4*NUM_REQ-1:0] req_a;
   logic [4*NUM_REQ-1:0] req_b;
   logic [4*NUM_REQ-1:0] req_op;
   logic [3:0]           alu_a;
   logic [3:0]           alu_b;
   logic [3:0]           alu_uc;
   logic [3:0]           alu_result;
   logic [3:0]           alu_flags;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [3:0]           rsp_result;
   logic [3:0]           rsp_flags;
   logic                 rsp_err;

   modport master (
      input  req_valid, req_a, req_b, req_op, alu_result, alu_flags, rsp_ready,
      output req_ready, alu_a, alu_b, alu_uc, rsp_valid, rsp_id, rsp_result,
             rsp_flags, rsp_err
   );

   modport slave (
      output req_valid, req_a, req_b, req_op, alu_result, alu_flags, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_uc, rsp_valid, rsp_id, rsp_result,
             rsp_flags, rsp_err
   );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU among NUM_REQ requesters, with a tagged response.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rotating pointer).
module alu_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   alu_rr_arbiter_if.master   bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    base;
   logic [ID_W-1:0]    win;
   logic               found;
   logic [NUM_REQ-1:0] grant;
   logic [3:0]         win_a, win_b, win_op;
   logic [ID_W-1:0]    id_q;
   logic               err_q;
   logic [3:0]         alu_a_q, alu_b_q, alu_uc_q;
   logic               rsp_valid_q, rsp_err_q;
   logic [ID_W-1:0]    rsp_id_q;
   logic [3:0]         rsp_result_q, rsp_flags_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign base = '0;
`else
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

   // Next search starts just past the requester that was last served.
   assign rr_ptr_d = (int'(id_q) == NUM_REQ - 1) ? '0 : id_q + ID_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  rr_ptr_q <= '0;
      else if (state_q == RESP && bus.rsp_ready) rr_ptr_q <= rr_ptr_d;
   end

   assign base = rr_ptr_q;
`endif

   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && bus.req_valid[(int'(base) + k) % NUM_REQ]) begin
            found = 1'b1;
            win   = ID_W'((int'(base) + k) % NUM_REQ);
         end
      end
   end

   assign win_a  = bus.req_a[4*int'(win) +: 4];
   assign win_b  = bus.req_b[4*int'(win) +: 4];
   assign win_op = bus.req_op[4*int'(win) +: 4];

   always_comb begin
      state_d = state_q;
      grant   = '0;
      case (state_q)
         IDLE: if (found) begin
            grant[win] = 1'b1;
            state_d    = EXEC;
         end
         EXEC: state_d = RESP;
         RESP: if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         id_q         <= '0;
         err_q        <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_uc_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (found) begin
               alu_a_q  <= win_a;
               alu_b_q  <= win_b;
               alu_uc_q <= win_op;
               id_q     <= win;
               err_q    <= (win_op > 4'd6);
            end
            // Illegal opcodes return zeros regardless of what the ALU produced.
            EXEC: begin
               rsp_result_q <= err_q ? 4'd0 : bus.alu_result;
               rsp_flags_q  <= err_q ? 4'd0 : bus.alu_flags;
               rsp_err_q    <= err_q;
               rsp_id_q     <= id_q;
               rsp_valid_q  <= 1'b1;
            end
            RESP: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = grant;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_uc     = alu_uc_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed + randomized bench for alu_rr_arbiter with a transaction-level reference model.
module tb_alu_rr_arbiter;
   localparam int NR = 2;
   localparam int IW = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   alu_rr_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus();
   alu_rr_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   logic [NR-1:0] rv;
   logic [3:0]    ra[NR], rb[NR], ro[NR];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] alu_res(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << b;
         4'd6: return a >> b;
         default: return 4'hA;
      endcase
   endfunction

   function automatic logic [3:0] alu_flg(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      logic [3:0] r;
      r = alu_res(a, b, op);
      return {r == 4'd0, r[3], a[3] ^ b[3], (op > 4'd6) ? 1'b1 : (a > b)};
   endfunction

   function automatic logic [NR-1:0] onehot(input int w);
      logic [NR-1:0] v;
      v = '0;
      v[w] = 1'b1;
      return v;
   endfunction

   function automatic int pick(input logic [NR-1:0] v, input int ptr);
      for (int k = 0; k < NR; k++)
         if (v[(ptr + k) % NR]) return (ptr + k) % NR;
      return -1;
   endfunction

   always_comb begin
      bus.req_valid = rv;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = '0;
      for (int i = 0; i < NR; i++) begin
         bus.req_a[4*i +: 4]  = ra[i];
         bus.req_b[4*i +: 4]  = rb[i];
         bus.req_op[4*i +: 4] = ro[i];
      end
   end

   always_comb begin
      bus.alu_result = alu_res(bus.alu_a, bus.alu_b, bus.alu_uc);
      bus.alu_flags  = alu_flg(bus.alu_a, bus.alu_b, bus.alu_uc);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      rv[i] = v;
      ra[i] = a;
      rb[i] = b;
      ro[i] = op;
   endtask

   int            m_ptr, m_age, m_id, w;
   logic          m_busy;
   logic [3:0]    m_a, m_b, m_op;
   logic [NR-1:0] granted, exp_rdy;
   logic          exp_v;
   logic [IW-1:0] exp_id;

   initial begin
      rv = '0;
      for (int i = 0; i < NR; i++) set_req(i, 1'b0, 4'd0, 4'd0, 4'd0);
      bus.rsp_ready = 1'b0;

      #1 rst = 1'b1;
      #2;
      chk("rst_ready", bus.req_ready, 2'b00);
      chk("rst_valid", bus.rsp_valid, 1'b0);
      chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_uc}, 12'h000);
      chk("rst_rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err}, 10'h000);

      tick();
      rst = 1'b0;
      set_req(0, 1'b1, 4'd3, 4'd4, 4'd0);
      bus.rsp_ready = 1'b1;
      #1;
      chk("add_grant", bus.req_ready, 2'b01);
      tick();
      rv[0] = 1'b0;
      #1;
      chk("add_exec_ready", bus.req_ready, 2'b00);
      chk("add_exec_valid", bus.rsp_valid, 1'b0);
      chk("add_alu_ops", {bus.alu_a, bus.alu_b, bus.alu_uc}, 12'h340);
      tick();
      chk("add_valid", bus.rsp_valid, 1'b1);
      chk("add_id", bus.rsp_id, 1'b0);
      chk("add_result", bus.rsp_result, 4'd7);
      chk("add_flags", bus.rsp_flags, alu_flg(4'd3, 4'd4, 4'd0));
      chk("add_err", bus.rsp_err, 1'b0);
      tick();
      chk("add_done", bus.rsp_valid, 1'b0);

      set_req(1, 1'b1, 4'd5, 4'd2, 4'd9);
      #1;
      chk("ill_grant", bus.req_ready, 2'b10);
      tick();
      rv[1] = 1'b0;
      tick();
      chk("ill_valid", bus.rsp_valid, 1'b1);
      chk("ill_err", bus.rsp_err, 1'b1);
      chk("ill_result", bus.rsp_result, 4'd0);
      chk("ill_flags", bus.rsp_flags, 4'd0);
      chk("ill_id", bus.rsp_id, 1'b1);
      tick();

      bus.rsp_ready = 1'b0;
      set_req(1, 1'b1, 4'd1, 4'd1, 4'd4);
      #1;
      chk("bp_grant1", bus.req_ready, 2'b10);
      tick();
      rv[1] = 1'b0;
      set_req(0, 1'b1, 4'd6, 4'd9, 4'd1);
      #1;
      chk("bp_exec_ready", bus.req_ready, 2'b00);
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("bp_hold_valid", bus.rsp_valid, 1'b1);
         chk("bp_hold_rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_err}, 6'b1_0000_0);
         chk("bp_hold_ready", bus.req_ready, 2'b00);
         tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      chk("bp_release_grant", bus.req_ready, 2'b01);
      chk("bp_release_valid", bus.rsp_valid, 1'b0);
      tick();
      rv[0] = 1'b0;
      tick();
      chk("bp_sub_result", bus.rsp_result, 4'hD);
      chk("bp_sub_id", bus.rsp_id, 1'b0);
      tick();

      set_req(1, 1'b1, 4'd2, 4'd3, 4'd2);
      #1;
      chk("mid_grant", bus.req_ready, 2'b10);
      tick();
      rv[1] = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", bus.req_ready, 2'b00);
      chk("mid_rst_valid", bus.rsp_valid, 1'b0);
      chk("mid_rst_alu", {bus.alu_a, bus.alu_b, bus.alu_uc}, 12'h000);
      chk("mid_rst_rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_flags, bus.rsp_err}, 10'h000);
      tick();
      rst = 1'b0;
      set_req(0, 1'b1, 4'd1, 4'd2, 4'd5);
      set_req(1, 1'b1, 4'd7, 4'd7, 4'd6);
      #1;
      chk("post_rst_grant", bus.req_ready, 2'b01);

      for (int t = 0; t < 4; t++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         w = 0;
`else
         w = t % 2;
`endif
         chk("both_grant", bus.req_ready, onehot(w));
         tick();
         tick();
         exp_id = IW'(w);
         chk("both_valid", bus.rsp_valid, 1'b1);
         chk("both_id", bus.rsp_id, exp_id);
         chk("both_result", bus.rsp_result, alu_res(ra[w], rb[w], ro[w]));
         tick();
      end

      rv     = '0;
      m_ptr  = 0;
      m_busy = 1'b0;
      m_age  = 0;
      m_id   = 0;
      #1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         w       = m_busy ? -1 : pick(rv, m_ptr);
         exp_rdy = (w >= 0) ? onehot(w) : '0;
         exp_v   = m_busy && (m_age >= 2);
         chk("rand_ready", bus.req_ready, exp_rdy);
         chk("rand_valid", bus.rsp_valid, exp_v);
         if (m_busy) chk("rand_alu", {bus.alu_a, bus.alu_b, bus.alu_uc}, {m_a, m_b, m_op});
         if (exp_v) begin
            exp_id = IW'(m_id);
            chk("rand_id", bus.rsp_id, exp_id);
            chk("rand_err", bus.rsp_err, (m_op > 4'd6));
            chk("rand_result", bus.rsp_result, (m_op > 4'd6) ? 4'd0 : alu_res(m_a, m_b, m_op));
            chk("rand_flags", bus.rsp_flags, (m_op > 4'd6) ? 4'd0 : alu_flg(m_a, m_b, m_op));
         end
         granted = '0;
         if (!m_busy) begin
            if (w >= 0) begin
               m_busy = 1'b1;
               m_age  = 1;
               m_id   = w;
               m_a    = ra[w];
               m_b    = rb[w];
               m_op   = ro[w];
               granted[w] = 1'b1;
            end
         end else if (m_age >= 2 && bus.rsp_ready) begin
            m_busy = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (m_id + 1) % NR;
`endif
         end else begin
            m_age++;
         end
         tick();
         for (int i = 0; i < NR; i++) begin
            if (granted[i] || !rv[i])
               set_req(i, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom_range(0, 9)));
            else if ($urandom_range(0, 9) == 0)
               rv[i] = 1'b0;
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one 4-bit ALU (opcodes 0..6: add, sub, and, or, xor, sll, srl) between NUM_REQ requesters.
- Round-robin arbitration over valid/ready request channels.
- Drives ALU operands and opcode from registers, captures the combinational ALU result and flags one cycle later, and returns them on a single tagged response channel.
- Sits between requester FSMs and the ALU datapath.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
ID_W, $clog2(NUM_REQ) (minimum 1), width of the requester index.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  NUM_REQ  request pending, one bit per requester.
req_ready  output  NUM_REQ  one-hot grant; a request transfers when req_valid[i] & req_ready[i].
req_a  input  4*NUM_REQ  operand A; requester i uses bits [4i+3:4i].
req_b  input  4*NUM_REQ  operand B, packed the same way.
req_op  input  4*NUM_REQ  opcode, packed the same way.
alu_a  output  4  ALU operand A (registered).
alu_b  output  4  ALU operand B (registered).
alu_uc  output  4  ALU opcode (registered).
alu_result  input  4  ALU result (combinational from alu_a/alu_b/alu_uc).
alu_flags  input  4  ALU flags (combinational).
rsp_valid  output  1  response available.
rsp_ready  input  1  consumer accepts the response.
rsp_id  output  ID_W  index of the requester that owns the response.
rsp_result  output  4  captured result.
rsp_flags  output  4  captured flags.
rsp_err  output  1  opcode was illegal (7..15).

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, req_ready=0, alu_a/alu_b/alu_uc=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0. Reset mid-operation drops any in-flight or pending response.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready is driven combinationally one-hot on the winner, and is 0 when no request is valid.
  - On the edge where a transfer occurs: latch the winner's a/b/op into alu_a/alu_b/alu_uc, store the id and err=(op>6), and go to EXEC.
- EXEC:
  - req_ready=0.
  - On the edge: rsp_result/rsp_flags <= alu_result/alu_flags when the opcode is legal, or 0/0 when illegal; rsp_err <= err; rsp_id <= id; rsp_valid <= 1; go to RESP.
- RESP:
  - req_ready=0.
  - rsp_* outputs are held stable while rsp_valid & !rsp_ready.
  - On the edge with rsp_ready=1: rsp_valid <= 0, rr_ptr <= (id+1) mod NUM_REQ, go to IDLE.
- alu_a/alu_b/alu_uc keep their last values outside EXEC; they are not cleared.
- Latency: grant edge to rsp_valid=1 is 2 cycles. Throughput is at best one operation per 3 cycles.
- Requests arriving in EXEC or RESP wait; they are never lost.
- req_valid is not required to be held by the arbiter; the requester must hold a/b/op stable while req_valid=1.
- If rsp_ready is already 1 when rsp_valid rises, the response completes on the next edge.
- rr_ptr wraps from NUM_REQ-1 to 0.
- A requester deasserting req_valid in IDLE before a grant is legal and is simply not selected.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins; rr_ptr is not implemented; rsp behaviour is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then req0 a=3 b=4 op=0 -> req_ready=01 for one cycle; 2 cycles later rsp_valid=1, id=0, result=7, flags=alu_flags, err=0.
- Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; one response per 3 cycles.
- req1 op=9 -> rsp_err=1, result=0, flags=0, id=1.
- rsp_ready=0 for 5 cycles -> rsp_* held stable, req_ready stays 0 despite pending req0; release -> req0 granted in the following IDLE cycle.
- Assert rst during EXEC -> all outputs 0 immediately (async); after release, the first grant goes to req0.
- With ALU_ARB_FIXED_PRIO_EN, both requesters continuously valid -> req0 always granted, rsp_id always 0.
